// File: rtl/piccolo_round_sched.sv
// Round scheduler for the Piccolo-80 datapath: accepts one block, steps the
// unrolled round register through ROUNDS/UNROLL groups, then holds the result.
module piccolo_round_sched #(
    parameter int ROUNDS = 25,
    parameter int UNROLL = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       dp_load,
    output logic       dp_en,
    output logic [4:0] dp_round,
    output logic [2:0] dp_mod5,
    output logic       dp_last,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam int         N        = ROUNDS / UNROLL;
    localparam logic [4:0] STEP     = 5'(UNROLL);
    localparam logic [3:0] MSTEP    = 4'(UNROLL % 5);
    localparam logic [4:0] LAST_GRP = 5'(N - 1);

    if (ROUNDS % UNROLL != 0) begin : g_bad_unroll
        $error("piccolo_round_sched: ROUNDS must be a multiple of UNROLL");
    end
    if (ROUNDS > 32 || ROUNDS < 1) begin : g_bad_rounds
        $error("piccolo_round_sched: ROUNDS must fit the 5-bit round index");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [4:0] grp;
    logic       accept;
    logic       last_grp;
    logic [3:0] mod_sum;
    logic [2:0] mod_next;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready never depends on in_valid, and flush masks acceptance.
    assign in_ready  = !flush && (state == IDLE || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign dp_load   = accept;
    assign dp_en     = (state == RUN);
    assign last_grp  = (grp == LAST_GRP);
    assign dp_last   = dp_en && last_grp;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Key-select phase advances modulo 5 by compare-and-subtract.
    assign mod_sum  = {1'b0, dp_mod5} + MSTEP;
    assign mod_next = (mod_sum >= 4'd5) ? 3'(mod_sum - 4'd5) : mod_sum[2:0];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state    <= IDLE;
            grp      <= '0;
            dp_round <= '0;
            dp_mod5  <= '0;
        end else if (accept) begin
            state    <= RUN;
            grp      <= '0;
            dp_round <= '0;
            dp_mod5  <= '0;
        end else begin
            case (state)
                RUN: begin
                    // The last group's round index is held so DONE reports it.
                    if (last_grp) begin
                        state <= DONE;
                    end else begin
                        grp      <= grp + 5'd1;
                        dp_round <= dp_round + STEP;
                        dp_mod5  <= mod_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state    <= IDLE;
                        grp      <= '0;
                        dp_round <= '0;
                        dp_mod5  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piccolo_round_sched.sv
// Bench for piccolo_round_sched: UNROLL=5 and UNROLL=1 instances share stimulus
// and are compared every cycle against a phase-number model of the schedule.
module tb_piccolo_round_sched;

    logic clk = 1'b0;
    logic reset, flush, in_valid, out_ready;

    logic       ir_a, ov_a, ld_a, en_a, last_a, busy_a;
    logic [4:0] rnd_a;
    logic [2:0] m5_a;
    logic [1:0] st_a;
    logic       ir_b, ov_b, ld_b, en_b, last_b, busy_b;
    logic [4:0] rnd_b;
    logic [2:0] m5_b;
    logic [1:0] st_b;

    int n_checks = 0;
    int n_pass   = 0;

    // Model phase: -1 idle, 0..N-1 group being computed, N holding result.
    int ph5 = -1;
    int ph1 = -1;
    logic model_ok = 1'b0;

    always #5 clk = ~clk;

    piccolo_round_sched #(.ROUNDS(25), .UNROLL(5)) u5 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(ir_a), .out_valid(ov_a), .out_ready(out_ready),
        .dp_load(ld_a), .dp_en(en_a), .dp_round(rnd_a), .dp_mod5(m5_a),
        .dp_last(last_a), .busy(busy_a), .dbg_state(st_a)
    );

    piccolo_round_sched #(.ROUNDS(25), .UNROLL(1)) u1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(ir_b), .out_valid(ov_b), .out_ready(out_ready),
        .dp_load(ld_b), .dp_en(en_b), .dp_round(rnd_b), .dp_mod5(m5_b),
        .dp_last(last_b), .busy(busy_b), .dbg_state(st_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int next_ph(input int ph, input int n);
        if (reset || flush) return -1;
        if (in_valid && (ph == -1 || (ph == n && out_ready))) return 0;
        if (ph >= 0 && ph < n) return ph + 1;
        if (ph == n && out_ready) return -1;
        return ph;
    endfunction

    always @(posedge clk) begin
        ph5      <= next_ph(ph5, 5);
        ph1      <= next_ph(ph1, 25);
        model_ok <= model_ok | reset;
    end

    task automatic check_inst(input string tag, input int ph, input int n, input int u,
                              input logic ir, input logic ov, input logic ld, input logic en,
                              input logic last, input logic bsy,
                              input logic [4:0] rnd, input logic [2:0] m5);
        logic exp_ir;
        int   exp_rnd;
        exp_ir  = !flush && (ph == -1 || (ph == n && out_ready));
        exp_rnd = (ph < 0) ? 0 : ((ph < n) ? ph : n - 1) * u;
        chk({tag, ".in_ready"},  32'(ir),   32'(exp_ir));
        chk({tag, ".dp_load"},   32'(ld),   32'(exp_ir && in_valid));
        chk({tag, ".out_valid"}, 32'(ov),   32'(ph == n));
        chk({tag, ".dp_en"},     32'(en),   32'(ph >= 0 && ph < n));
        chk({tag, ".dp_last"},   32'(last), 32'(ph == n - 1));
        chk({tag, ".busy"},      32'(bsy),  32'(ph >= 0));
        chk({tag, ".dp_round"},  32'(rnd),  32'(exp_rnd));
        chk({tag, ".dp_mod5"},   32'(m5),   32'(exp_rnd % 5));
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            check_inst("u5", ph5, 5, 5, ir_a, ov_a, ld_a, en_a, last_a, busy_a, rnd_a, m5_a);
            check_inst("u1", ph1, 25, 1, ir_b, ov_b, ld_b, en_b, last_b, busy_b, rnd_b, m5_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] r5 [5];
        r5 = '{5'd0, 5'd5, 5'd10, 5'd15, 5'd20};
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst.in_ready", 32'(ir_a), 32'd1);
        chk("rst.busy", 32'(busy_a), 32'd0);
        chk("rst.out_valid", 32'(ov_a), 32'd0);
        chk("rst.dp_round", 32'(rnd_a), 32'd0);
        chk("rst.dp_en", 32'(en_a), 32'd0);
        tick();

        // Cycle 0: accept on both instances.
        in_valid = 1'b1;
        @(negedge clk);
        chk("acc.dp_load_u5", 32'(ld_a), 32'd1);
        chk("acc.dp_load_u1", 32'(ld_b), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < 30; c++) begin
            @(negedge clk);
            if (c <= 5) begin
                chk("u5.run_round", 32'(rnd_a), 32'(r5[c-1]));
                chk("u5.run_mod5", 32'(m5_a), 32'd0);
                chk("u5.run_last", 32'(last_a), 32'(c == 5));
            end else begin
                chk("u5.done_round", 32'(rnd_a), 32'd20);
            end
            chk("u5.out_valid_time", 32'(ov_a), 32'(c >= 6));
            if (c <= 25) begin
                chk("u1.run_round", 32'(rnd_b), 32'(c - 1));
                chk("u1.run_last", 32'(last_b), 32'(c == 25));
            end
            chk("u1.out_valid_time", 32'(ov_b), 32'(c >= 26));
            tick();
        end

        // Back-to-back accept out of DONE, then in_valid held during RUN.
        out_ready = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("b2b.dp_load_u5", 32'(ld_a), 32'd1);
        chk("b2b.dp_load_u1", 32'(ld_b), 32'd1);
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("b2b.run_en", 32'(en_a), 32'd1);
        chk("b2b.run_in_ready", 32'(ir_a), 32'd0);
        chk("b2b.run_no_load", 32'(ld_a), 32'd0);
        tick();
        @(negedge clk);
        chk("b2b.run_round", 32'(rnd_a), 32'd5);
        tick();

        // Flush mid-run, with in_valid still high: no accept on the flush cycle.
        flush = 1'b1;
        @(negedge clk);
        chk("flush.in_ready", 32'(ir_a), 32'd0);
        chk("flush.no_load", 32'(ld_a), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("flush.no_out_valid", 32'(ov_a), 32'd0);
            chk("flush.idle", 32'(busy_a), 32'd0);
            tick();
        end

        // Reset in the middle of a run.
        in_valid = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rstrun.in_ready", 32'(ir_a), 32'd0);
        tick();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rstrun.busy", 32'(busy_a), 32'd0);
        chk("rstrun.dp_round", 32'(rnd_a), 32'd0);
        chk("rstrun.in_ready", 32'(ir_a), 32'd1);
        tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
